vga_fade_stage: RTL

VGA_FADE_STAGE -- requirements
Module: vga_fade_stage

---
 rtl/vga_fade_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_fade_stage.sv
// Brightness fade stage between the object mux and the VGA DAC: scales each
// pixel by a level 0..8 that steps once every FRAMES_PER_STEP frames.
module vga_fade_stage #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] RGBIn,
  input  logic       startOfFrame,
  input  logic       fadeOutReq,
  input  logic       fadeInReq,
  output logic [7:0] RGBOut,
  output logic [3:0] fadeLevel,
  output logic       busy,
  output logic       fadeDone,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    BRIGHT  = 2'd0,
    DIM_OUT = 2'd1,
    DARK    = 2'd2,
    DIM_IN  = 2'd3
  } fade_state_t;

  localparam logic [7:0] LP_LAST_CNT = 8'(FRAMES_PER_STEP - 1);
  localparam logic [3:0] LP_LEVEL_MAX = 4'd8;

  fade_state_t r_state;
  logic [3:0]  r_level;
  logic [7:0]  r_frame_cnt;
  logic        r_fade_done;
  logic [7:0]  r_rgb_out;

  fade_state_t w_step_state;
  fade_state_t w_state_nxt;
  logic [3:0]  w_level_nxt;
  logic [7:0]  w_step_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        w_done_nxt;
  logic        w_fading;

  logic [6:0]  w_r_prod;
  logic [6:0]  w_g_prod;
  logic [5:0]  w_b_prod;
  logic [7:0]  w_rgb_scaled;

  assign w_fading = (r_state == DIM_OUT) || (r_state == DIM_IN);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= BRIGHT;
      r_level     <= LP_LEVEL_MAX;
      r_frame_cnt <= 8'd0;
      r_fade_done <= 1'b0;
      r_rgb_out   <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_fade_done <= w_done_nxt;
      r_rgb_out   <= w_rgb_scaled;
    end
  end

  // Frame step is resolved first; requests then act on the stepped state/level.
  always_comb begin
    w_step_state = r_state;
    w_level_nxt  = r_level;
    w_step_cnt   = r_frame_cnt;
    w_done_nxt   = 1'b0;
    if (startOfFrame && w_fading) begin
      if (r_frame_cnt == LP_LAST_CNT) begin
        w_step_cnt = 8'd0;
        if (r_state == DIM_OUT) begin
          w_level_nxt = r_level - 4'd1;
          if (r_level == 4'd1) begin
            w_step_state = DARK;
            w_done_nxt   = 1'b1;
          end
        end else begin
          w_level_nxt = r_level + 4'd1;
          if (r_level == LP_LEVEL_MAX - 4'd1) begin
            w_step_state = BRIGHT;
            w_done_nxt   = 1'b1;
          end
        end
      end else begin
        w_step_cnt = r_frame_cnt + 8'd1;
      end
    end

    w_state_nxt = w_step_state;
    w_cnt_nxt   = w_step_cnt;
    if (fadeOutReq) begin
      if ((w_step_state == BRIGHT) || (w_step_state == DIM_IN)) begin
        w_state_nxt = DIM_OUT;
        w_cnt_nxt   = 8'd0;
      end
    end else if (fadeInReq) begin
      if ((w_step_state == DARK) || (w_step_state == DIM_OUT)) begin
        w_state_nxt = DIM_IN;
        w_cnt_nxt   = 8'd0;
      end
    end
  end

  // Full-width products, then divide by 8; level 8 is an exact pass-through.
  always_comb begin
    w_r_prod     = 7'(RGBIn[7:5]) * 7'(r_level);
    w_g_prod     = 7'(RGBIn[4:2]) * 7'(r_level);
    w_b_prod     = 6'(RGBIn[1:0]) * 6'(r_level);
    w_rgb_scaled = {3'(w_r_prod >> 3), 3'(w_g_prod >> 3), 2'(w_b_prod >> 3)};
  end

  assign RGBOut      = r_rgb_out;
  assign fadeLevel   = r_level;
  assign busy        = w_fading;
  assign fadeDone    = r_fade_done;
  assign o_dbg_state = r_state;

endmodule
